// File: rtl/btn_db_pkg.sv
// Shared types and defaults for the button debouncer.
// Encodings keep the level in bit 1 and the "timing" flag in bit 0 ^ bit 1.
package btn_db_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } db_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 500000;

endpackage

// File: rtl/btn_debounce_sync_sync.sv
// Generic N-flop synchroniser chain, async active-high reset to 0.
// Reusable for any other single-bit board input.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_sync.sv
// Button synchroniser + debouncer with clean level and edge pulses.
// Define BTN_DB_TOGGLE_EN to get a T-flop output driven by each press.
module btn_debounce_sync
  import btn_db_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy,
  output logic btn_toggle
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic s;

  db_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (s)
  );

  // Abort on reversal beats acceptance, so a glitch always restarts the run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign busy      = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef BTN_DB_TOGGLE_EN
  logic tog_q, tog_d;

  always_comb begin
    tog_d = tog_q ^ rise_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tog_q <= 1'b0;
    else     tog_q <= tog_d;
  end

  assign btn_toggle = tog_q;
`else
  assign btn_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Bench for btn_debounce_sync with SYNC_STAGES=2, DB_CYCLES=4.
// Output bundle order: {level, rise, fall, busy, toggle}.
module tb_btn_debounce_sync;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic busy;
  logic btn_toggle;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];

`ifdef BTN_DB_TOGGLE_EN
  localparam logic [4:0] TOG_MASK = 5'b11111;
`else
  localparam logic [4:0] TOG_MASK = 5'b11110;
`endif

  btn_debounce_sync #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .busy      (busy),
    .btn_toggle(btn_toggle)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [4:0] outs();
    return {btn_level, btn_rise, btn_fall, busy, btn_toggle};
  endfunction

  task automatic chk(input string name, input logic [4:0] act,
                     input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic b, input logic [4:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e & TOG_MASK;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic b, input logic [4:0] e);
    for (int i = 0; i < n; i++) add(b, e);
  endtask

  initial begin
    logic [4:0] e;
    logic [4:0] bnc_busy;
    logic [7:0] bnc_pat;
    int         lat;

    n_cmp = 0;
    n_err = 0;

    // clean press out of reset
    addn(2, 1'b1, 5'b00000);
    addn(4, 1'b1, 5'b00010);
    add (1'b1, 5'b11001);
    add (1'b1, 5'b10001);
    // release
    addn(2, 1'b0, 5'b10001);
    addn(4, 1'b0, 5'b10011);
    add (1'b0, 5'b00101);
    add (1'b0, 5'b00001);
    // bounce 1,1,0,1,0,1,1,0 then held high
    bnc_pat = 8'b0110_1011;
    for (int i = 0; i < 14; i++) begin
      bnc_busy = 5'b0;
      case (i)
        2, 3, 5, 7, 8, 10, 11, 12, 13: bnc_busy = 5'b00010;
        default: bnc_busy = 5'b00000;
      endcase
      add((i < 8) ? bnc_pat[i] : 1'b1, bnc_busy | 5'b00001);
    end
    add(1'b1, 5'b11000);
    add(1'b1, 5'b10000);
    // second release
    addn(2, 1'b0, 5'b10000);
    addn(4, 1'b0, 5'b10010);
    add (1'b0, 5'b00100);
    add (1'b0, 5'b00000);

    // reset held with the pin high
    rst    = 1'b1;
    btn_in = 1'b1;
    #5;
    chk("rst_async_before_edge", outs(), 5'b00000);
    #95;
    chk("rst_held_100ns", outs(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      btn_in = vecs[i].btn;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), outs(), e);
      if (btn_rise && btn_fall) chk("rise_fall_overlap", 5'b11111, 5'b0);
      @(negedge clk);
    end

    // async reset in the middle of a wait
    btn_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midwait_busy", {4'b0, busy}, 5'b00001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midwait_rst_async", outs(), 5'b00000);
    @(posedge clk);
    #1;
    chk("midwait_rst_held", outs(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (btn_level) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("restart_timeout", 5'b00000, 5'b10000);
    else          chk("restart_latency", 5'(lat), 5'd7);
    chk("restart_outs", outs(), 5'b11001 & TOG_MASK);
    @(posedge clk);
    #1;
    chk("restart_rise_clear", outs(), 5'b10001 & TOG_MASK);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
